// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS frequency word.
// Steps freq_out from f_start to f_stop in f_step increments, holding each
// value for D = max(dwell, 1) clocks. Mode 0 sweeps up once; mode 1 bounces
// between f_start and f_stop indefinitely until aborted.
module dds_sweep_ctrl #(
    parameter int FREQ_W  = 20,
    parameter int DWELL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [FREQ_W-1:0] cfg_wdata,
    input  logic              mode,
    input  logic              start,
    input  logic              abort,
    output logic [FREQ_W-1:0] freq_out,
    output logic              freq_vld,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [FREQ_W-1:0]   r_f_start, r_f_stop, r_f_step;
    logic [DWELL_W-1:0]  r_dwell;
    logic [FREQ_W-1:0]   r_freq, w_freq_nxt;
    logic [DWELL_W-1:0]  r_cnt, w_cnt_nxt;
    logic                r_mode, w_mode_nxt;
    logic                r_dir_up, w_dir_up_nxt;
    logic                r_vld, w_vld_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;

    logic [DWELL_W-1:0]  w_dwell_last;
    logic [FREQ_W:0]     w_sum, w_diff;
    logic [FREQ_W-1:0]   w_up_val, w_dn_val;
    logic                w_start_ok, w_cfg_ok;

    // Last count value of a dwell period; a zero dwell behaves like one.
    assign w_dwell_last = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);

    // One extra bit keeps the step arithmetic from wrapping at either end.
    assign w_sum    = {1'b0, r_freq} + {1'b0, r_f_step};
    assign w_diff   = {1'b0, r_freq} - {1'b0, r_f_step};
    assign w_up_val = (w_sum > {1'b0, r_f_stop}) ? r_f_stop : w_sum[FREQ_W-1:0];
    assign w_dn_val = (w_diff[FREQ_W] || (w_diff[FREQ_W-1:0] < r_f_start))
                      ? r_f_start : w_diff[FREQ_W-1:0];

    assign w_start_ok = (r_f_start <= r_f_stop) && (r_f_step != '0);
    assign w_cfg_ok   = cfg_we && (r_state == S_IDLE);

    // Config register file; only writable while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_f_step  <= '0;
            r_dwell   <= '0;
        end else if (w_cfg_ok) begin
            case (cfg_addr)
                2'd0:    r_f_start <= cfg_wdata;
                2'd1:    r_f_stop  <= cfg_wdata;
                2'd2:    r_f_step  <= cfg_wdata;
                default: r_dwell   <= cfg_wdata[DWELL_W-1:0];
            endcase
        end
    end

    // Sweep state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_freq   <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_dir_up <= 1'b1;
            r_vld    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_freq   <= w_freq_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mode   <= w_mode_nxt;
            r_dir_up <= w_dir_up_nxt;
            r_vld    <= w_vld_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state logic: start/abort handling, dwell counting and stepping.
    always_comb begin
        w_state_nxt  = r_state;
        w_freq_nxt   = r_freq;
        w_cnt_nxt    = r_cnt;
        w_mode_nxt   = r_mode;
        w_dir_up_nxt = r_dir_up;
        w_vld_nxt    = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_err_nxt    = cfg_we && (r_state == S_RUN);

        case (r_state)
            S_IDLE: begin
                if (!abort && start) begin
                    if (w_start_ok) begin
                        w_state_nxt  = S_RUN;
                        w_mode_nxt   = mode;
                        w_freq_nxt   = r_f_start;
                        w_dir_up_nxt = 1'b1;
                        w_cnt_nxt    = '0;
                        w_vld_nxt    = 1'b1;
                        w_busy_nxt   = 1'b1;
                    end else begin
                        w_err_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    // Abort beats a coincident step; freq_out freezes.
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt != w_dwell_last) begin
                    w_cnt_nxt = r_cnt + DWELL_W'(1);
                end else begin
                    w_cnt_nxt = '0;
                    if (r_dir_up) begin
                        if (r_freq == r_f_stop) begin
                            if (!r_mode) begin
                                w_state_nxt = S_IDLE;
                                w_busy_nxt  = 1'b0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_dir_up_nxt = 1'b0;
                                w_freq_nxt   = w_dn_val;
                                w_vld_nxt    = 1'b1;
                            end
                        end else begin
                            w_freq_nxt = w_up_val;
                            w_vld_nxt  = 1'b1;
                        end
                    end else begin
                        if (r_freq == r_f_start) begin
                            w_dir_up_nxt = 1'b1;
                            w_freq_nxt   = w_up_val;
                        end else begin
                            w_freq_nxt   = w_dn_val;
                        end
                        w_vld_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    assign freq_out = r_freq;
    assign freq_vld = r_vld;
    assign busy     = r_busy;
    assign done     = r_done;
    assign cfg_err  = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl. Expected sweeps are built as value
// lists from the sweep rules; each value is expected for D cycles in turn.
module tb_dds_sweep_ctrl;

    localparam int FREQ_W  = 20;
    localparam int DWELL_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [FREQ_W-1:0] cfg_wdata;
    logic              mode;
    logic              start;
    logic              abort;
    logic [FREQ_W-1:0] freq_out;
    logic              freq_vld;
    logic              busy;
    logic              done;
    logic              cfg_err;

    int checks   = 0;
    int failures = 0;
    logic [FREQ_W-1:0] m_freq = '0;

    dds_sweep_ctrl #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .mode(mode), .start(start), .abort(abort),
        .freq_out(freq_out), .freq_vld(freq_vld), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_cycle(input string tag, input int c, input logic [FREQ_W-1:0] ef,
                               input logic ev, input logic eb, input logic ed, input logic ee);
        checks++;
        if (freq_out !== ef || freq_vld !== ev || busy !== eb || done !== ed || cfg_err !== ee) begin
            failures++;
            $display("FAIL %s c=%0d freq=%0d exp %0d vld=%b exp %b busy=%b exp %b done=%b exp %b err=%b exp %b",
                     tag, c, freq_out, ef, freq_vld, ev, busy, eb, done, ed, cfg_err, ee);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input int unsigned d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = FREQ_W'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    function automatic int eff_dwell(input int unsigned wd);
        int unsigned d;
        d = wd & 32'h0000_FFFF;
        return (d == 0) ? 1 : int'(d);
    endfunction

    // Mode-0 sweep; optional rejected write at cycle wr_at, abort at ab_at (0 = none).
    task automatic run_single(input string tag, input int unsigned fs, input int unsigned fe,
                              input int unsigned st, input int unsigned wd,
                              input int wr_at, input int ab_at);
        int unsigned seq[$];
        int unsigned v;
        int dd, len, last, ce, idx;
        logic run_e;
        logic [FREQ_W-1:0] ef;
        dd = eff_dwell(wd);
        v = fs;
        seq.push_back(v);
        while (v != fe) begin
            v = (v + st > fe) ? fe : v + st;
            seq.push_back(v);
        end
        len  = seq.size();
        last = (ab_at > 0) ? ab_at + 6 : len * dd + 3;
        cfg_write(2'd0, fs); cfg_write(2'd1, fe); cfg_write(2'd2, st); cfg_write(2'd3, wd);
        mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ef = '0;
        for (int c = 1; c <= last; c++) begin
            ce    = (ab_at > 0 && c > ab_at) ? ab_at : c;
            run_e = (ce <= len * dd) && !(ab_at > 0 && c > ab_at);
            idx   = (ce - 1) / dd;
            if (idx > len - 1) idx = len - 1;
            ef = FREQ_W'(seq[idx]);
            check_cycle(tag, c, ef, run_e && ((c - 1) % dd == 0), run_e,
                        (ab_at == 0) && (c == len * dd + 1), (wr_at > 0) && (c == wr_at + 1));
            cfg_we    = (c == wr_at);
            cfg_addr  = 2'd2;
            cfg_wdata = 20'd777;
            abort     = (c == ab_at);
            @(negedge clk);
        end
        cfg_we = 1'b0; abort = 1'b0;
        m_freq = ef;
    endtask

    // Mode-1 triangle sweep for n cycles, then aborted.
    task automatic run_tri(input string tag, input int unsigned fs, input int unsigned fe,
                           input int unsigned st, input int unsigned wd, input int n);
        int unsigned seq[$];
        int unsigned v;
        int dd;
        logic [FREQ_W-1:0] ef;
        dd = eff_dwell(wd);
        seq.push_back(fs);
        while (seq.size() < n + 2) begin
            v = fs;
            do begin v = (v + st > fe) ? fe : v + st; seq.push_back(v); end while (v != fe);
            do begin v = (v >= fs + st) ? v - st : fs; seq.push_back(v); end while (v != fs);
        end
        cfg_write(2'd0, fs); cfg_write(2'd1, fe); cfg_write(2'd2, st); cfg_write(2'd3, wd);
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            check_cycle(tag, c, FREQ_W'(seq[(c - 1) / dd]), ((c - 1) % dd == 0), 1'b1, 1'b0, 1'b0);
            start = (c == 5);   // start while running must be ignored
            abort = (c == n);
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0;
        ef = FREQ_W'(seq[(n - 1) / dd]);
        check_cycle({tag, "_abort"}, n + 1, ef, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_cycle({tag, "_idle"}, n + 2, ef, 1'b0, 1'b0, 1'b0, 1'b0);
        mode = 1'b0;
        m_freq = ef;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        mode = 1'b0; start = 1'b0; abort = 1'b0;
        #1;
        check_cycle("reset_async", 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_cycle("reset_held", 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_cycle("reset_release", 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        run_single("single", 100, 130, 10, 3, 0, 0);
    endtask

    task automatic test_clamp();
        run_single("clamp", 100, 130, 25, 3, 0, 0);
    endtask

    task automatic test_triangle();
        run_tri("triangle", 100, 130, 10, 1, 30);
    endtask

    task automatic test_abort();
        run_single("abort", 100, 130, 10, 3, 0, 5);
    endtask

    task automatic test_invalid();
        cfg_write(2'd0, 200); cfg_write(2'd1, 100); cfg_write(2'd2, 10); cfg_write(2'd3, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cycle("invalid_err", 1, m_freq, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_cycle("invalid_after", 2, m_freq, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rejected_write();
        run_single("rej_write", 100, 200, 10, 2, 4, 0);
    endtask

    task automatic test_boundaries();
        run_single("dwell_hi_bits", 40, 70, 10, 32'h10002, 0, 0);
        run_single("dwell_zero", 7, 9, 1, 0, 0, 0);
        run_single("top_no_wrap", 20'hFFFC0, 20'hFFFFF, 20'h80000, 2, 0, 0);
        run_single("start_eq_stop", 500, 500, 3, 2, 0, 0);
        run_tri("tri_bottom", 5, 40, 20'hFFFFF, 2, 20);
        run_tri("tri_flat", 300, 300, 7, 2, 12);
    endtask

    task automatic test_random();
        int unsigned fs, fe, st, wd;
        for (int i = 0; i < 6; i++) begin
            fs = $urandom_range(0, 1000);
            fe = fs + $urandom_range(0, 200);
            st = $urandom_range(1, 80);
            wd = $urandom_range(0, 4);
            run_single("rand_single", fs, fe, st, wd, 0, (i == 3) ? 3 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            fs = $urandom_range(0, 1000);
            fe = fs + $urandom_range(0, 100);
            st = $urandom_range(1, 60);
            wd = $urandom_range(0, 3);
            run_tri("rand_tri", fs, fe, st, wd, 50);
        end
    endtask

    task automatic test_async_reset();
        cfg_write(2'd0, 100); cfg_write(2'd1, 130); cfg_write(2'd2, 10); cfg_write(2'd3, 3);
        mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_cycle("async_rst_now", 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_cycle("async_rst_idle", c, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Config was cleared too, so a fresh start is rejected (step == 0).
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cycle("async_rst_cfg", 1, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        m_freq = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_clamp();
        test_triangle();
        test_abort();
        test_invalid();
        test_rejected_write();
        test_boundaries();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
